// File: rtl/dct_mul_share_arb_if.sv
// Requester-side bus of dct_mul_share_arb: packed per-requester operands with
// valid/ready, plus the tagged one-hot result strobe shared by all requesters.
interface dct_mul_share_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int A_W     = 16,
    parameter int B_W     = 15,
    parameter int P_W     = 29
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [P_W-1:0]         rsp_p;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_p, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_p, busy
    );
endinterface

// File: rtl/dct_mul_share_arb.sv
// Round-robin time-sharing of one pipelined signed multiplier among NUM_REQ requesters.
// Define DCT_MUL_ARB_STATS_EN to add saturating stat_ops / stat_stall counters.
module dct_mul_share_arb #(
    parameter int NUM_REQ = 2,
    parameter int MUL_LAT = 3,
    parameter int A_W     = 16,
    parameter int B_W     = 15,
    parameter int P_W     = 29
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               ap_ce,
    dct_mul_share_arb_if.slave bus
`ifdef DCT_MUL_ARB_STATS_EN
    ,
    output logic [31:0]        stat_ops,
    output logic [31:0]        stat_stall
`endif
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [NUM_REQ-1:0]    grant;
    logic signed [A_W-1:0] sel_a;
    logic signed [B_W-1:0] sel_b;
    logic [MUL_LAT-1:0]    vld;
    logic [PTR_W-1:0]      tag [MUL_LAT];

    // Two passes: lowest valid index at or above ptr, else lowest valid overall.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!grant_any && bus.req_valid[j] && (32'(ptr) <= j)) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!grant_any && bus.req_valid[j]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(j);
            end
        end
        if (ap_rst || !ap_ce) begin
            grant_any = 1'b0;
        end
        grant = '0;
        sel_a = '0;
        sel_b = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            grant[j] = grant_any && (grant_idx == PTR_W'(j));
            if (grant[j]) begin
                sel_a = bus.req_a[j*A_W +: A_W];
                sel_b = bus.req_b[j*B_W +: B_W];
            end
        end
    end

    assign bus.req_ready = grant;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr <= '0;
        end else if (ap_ce && grant_any) begin
            ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            vld <= '0;
            for (int unsigned k = 0; k < MUL_LAT; k++) begin
                tag[k] <= '0;
            end
        end else if (ap_ce) begin
            vld[0] <= grant_any;
            tag[0] <= grant_idx;
            for (int unsigned k = 1; k < MUL_LAT; k++) begin
                vld[k] <= vld[k-1];
                tag[k] <= tag[k-1];
            end
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            bus.rsp_valid[j] = vld[MUL_LAT-1] && (tag[MUL_LAT-1] == PTR_W'(j));
        end
    end

    assign bus.busy = |vld;

    // Operands are sign-extended to P_W first: the P_W-bit product then equals
    // the low P_W bits of the full A_W+B_W product without unused upper bits.
    if (MUL_LAT == 1) begin : g_direct
        logic signed [P_W-1:0] ext_a;
        logic signed [P_W-1:0] ext_b;
        logic [P_W-1:0]        p_q;

        assign ext_a = P_W'(sel_a);
        assign ext_b = P_W'(sel_b);

        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                p_q <= '0;
            end else if (ap_ce && grant_any) begin
                p_q <= ext_a * ext_b;
            end
        end

        assign bus.rsp_p = p_q;
    end else begin : g_pipe
        logic signed [A_W-1:0] a_q;
        logic signed [B_W-1:0] b_q;
        logic signed [P_W-1:0] ext_a;
        logic signed [P_W-1:0] ext_b;
        logic [P_W-1:0]        p_q [1:MUL_LAT-1];

        assign ext_a = P_W'(a_q);
        assign ext_b = P_W'(b_q);

        // Product registers load only behind a valid stage so rsp_p holds when idle.
        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                a_q <= '0;
                b_q <= '0;
                for (int unsigned k = 1; k < MUL_LAT; k++) begin
                    p_q[k] <= '0;
                end
            end else if (ap_ce) begin
                if (grant_any) begin
                    a_q <= sel_a;
                    b_q <= sel_b;
                end
                if (vld[0]) begin
                    p_q[1] <= ext_a * ext_b;
                end
                for (int unsigned k = 2; k < MUL_LAT; k++) begin
                    if (vld[k-1]) begin
                        p_q[k] <= p_q[k-1];
                    end
                end
            end
        end

        assign bus.rsp_p = p_q[MUL_LAT-1];
    end

`ifdef DCT_MUL_ARB_STATS_EN
    logic stall_now;
    assign stall_now = ap_ce && (|(bus.req_valid & ~grant));

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (ap_ce && grant_any && (stat_ops != '1)) begin
                stat_ops <= stat_ops + 32'd1;
            end
            if (stall_now && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dct_mul_share_arb.sv
// Randomized bench for dct_mul_share_arb against a list-of-in-flight-ops model
// with countdowns; stat counters are checked when DCT_MUL_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_dct_mul_share_arb;
    localparam int N  = 2;
    localparam int L  = 3;
    localparam int AW = 16;
    localparam int BW = 15;
    localparam int PW = 29;

    logic ap_clk;
    logic ap_rst;
    logic ap_ce;
    int   checks   = 0;
    int   failures = 0;

    dct_mul_share_arb_if #(.NUM_REQ(N), .A_W(AW), .B_W(BW), .P_W(PW)) bus ();

`ifdef DCT_MUL_ARB_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_stall;
`endif

    dct_mul_share_arb #(
        .NUM_REQ(N), .MUL_LAT(L), .A_W(AW), .B_W(BW), .P_W(PW)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .ap_ce (ap_ce),
        .bus   (bus)
`ifdef DCT_MUL_ARB_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_stall(stat_stall)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int          tag;
        logic [PW-1:0] p;
        int          cnt;
    } op_t;

    op_t                   fly[$];
    int                    ptr_m;
    logic [N-1:0]          exp_rv;
    logic [PW-1:0]         exp_p;
    longint                ops_m;
    longint                stall_m;
    logic [N-1:0]          vld;
    logic signed [AW-1:0]  opa [N];
    logic signed [BW-1:0]  opb [N];
    int                    prob [N];
    int                    ce_pct;

    always_comb begin
        bus.req_valid = vld;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*AW +: AW] = opa[i];
            bus.req_b[i*BW +: BW] = opb[i];
        end
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mul_ref(int a, int b);
        longint f;
        f = longint'(a) * longint'(b);
        return f[PW-1:0];
    endfunction

    function automatic int pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (j == (p + k) % N && v[j]) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        fly.delete();
        ptr_m   = 0;
        exp_rv  = '0;
        exp_p   = '0;
        ops_m   = 0;
        stall_m = 0;
    endtask

    task automatic gen();
        for (int i = 0; i < N; i++) begin
            if (!vld[i] && $urandom_range(0, 99) < prob[i]) begin
                vld[i] = 1'b1;
                opa[i] = AW'($urandom);
                opb[i] = BW'($urandom);
            end
        end
        ap_ce = ($urandom_range(0, 99) < ce_pct);
    endtask

    // Called just after a negedge with inputs already driven for this cycle.
    task automatic cycle();
        int           g;
        logic [N-1:0] rdy_m;
        op_t          keep[$];
        #1;
        g     = (ap_ce && !ap_rst) ? pick(vld, ptr_m) : -1;
        rdy_m = (g >= 0) ? (N'(1) << g) : '0;
        check("req_ready", 64'(bus.req_ready), 64'(rdy_m));
        check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        check("rsp_p",     64'(bus.rsp_p),     64'(exp_p));
        check("busy",      64'(bus.busy),      64'(fly.size() != 0));
`ifdef DCT_MUL_ARB_STATS_EN
        check("stat_ops",   64'(stat_ops),   64'(ops_m));
        check("stat_stall", 64'(stat_stall), 64'(stall_m));
`endif
        @(posedge ap_clk);
        @(negedge ap_clk);
        if (ap_ce) begin
            if (g >= 0) ops_m++;
            if ((vld & ~rdy_m) != '0) stall_m++;
            foreach (fly[i]) begin
                if (fly[i].cnt > 0) keep.push_back('{fly[i].tag, fly[i].p, fly[i].cnt - 1});
            end
            if (g >= 0) begin
                keep.push_back('{g, mul_ref(int'(opa[g]), int'(opb[g])), L - 1});
                ptr_m = (g + 1) % N;
                vld   = vld & ~(N'(1) << g);
            end
            fly    = keep;
            exp_rv = '0;
            foreach (fly[i]) begin
                if (fly[i].cnt == 0) begin
                    exp_rv = N'(1) << fly[i].tag;
                    exp_p  = fly[i].p;
                end
            end
        end
        gen();
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) prob[i] = 0;
        ce_pct = 100;
        ap_ce  = 1'b1;
        repeat (L + 2) cycle();
    endtask

    initial begin
        ap_rst = 1'b1;
        ap_ce  = 1'b0;
        vld    = '0;
        for (int i = 0; i < N; i++) begin
            opa[i]  = '0;
            opb[i]  = '0;
            prob[i] = 0;
        end
        ce_pct = 100;
        model_reset();
        repeat (2) @(negedge ap_clk);

        // Reset holds ready low even with a valid request and ce present
        vld[0] = 1'b1;
        opa[0] = 16'sd100;
        opb[0] = -15'sd3;
        ap_ce  = 1'b1;
        #1;
        check("rst_ready",     64'(bus.req_ready), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_p",     64'(bus.rsp_p),     64'(0));
        check("rst_busy",      64'(bus.busy),      64'(0));
        @(negedge ap_clk);
        ap_rst = 1'b0;

        // 100 * -3, single op
        cycle();
        repeat (L + 1) cycle();

        // Both requesters continuously valid: alternating grants
        for (int i = 0; i < N; i++) prob[i] = 100;
        gen();
        ap_ce = 1'b1;
        repeat (10) cycle();
        drain();

        // Wrap and max-positive products
        vld[0] = 1'b1; opa[0] = -16'sd32768; opb[0] = -15'sd16384;
        cycle();
        vld[0] = 1'b1; opa[0] = 16'sd32767;  opb[0] = 15'sd16383;
        cycle();
        drain();

        // ce low for 5 cycles right after an issue, with another request waiting
        vld[0] = 1'b1; opa[0] = -16'sd1234; opb[0] = 15'sd777;
        ap_ce  = 1'b1;
        cycle();
        vld[1] = 1'b1; opa[1] = 16'sd4321; opb[1] = -15'sd999;
        repeat (5) begin
            ap_ce = 1'b0;
            cycle();
        end
        drain();

        // Single active requester runs at full rate
        prob[1] = 100;
        gen();
        ap_ce = 1'b1;
        repeat (8) cycle();
        drain();

        // Reset mid-flight
        prob[0] = 100;
        gen();
        ap_ce = 1'b1;
        repeat (2) cycle();
        #2;
        ap_rst = 1'b1;
        #1;
        check("mid_rst_ready",     64'(bus.req_ready), 64'(0));
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("mid_rst_rsp_p",     64'(bus.rsp_p),     64'(0));
        check("mid_rst_busy",      64'(bus.busy),      64'(0));
        model_reset();
        vld     = '0;
        prob[0] = 0;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        drain();
        // Pointer restarts at requester 0; both valid for 10 cycles
        for (int i = 0; i < N; i++) prob[i] = 100;
        gen();
        ap_ce = 1'b1;
        repeat (10) cycle();
        drain();

        // Long random run with random ce
        for (int i = 0; i < N; i++) prob[i] = 40;
        ce_pct = 80;
        gen();
        repeat (3000) cycle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
